// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: shared instruction/data memory port between the control FSM and the memory.
interface multicycle_control_fsm_if;
   logic mem_read_o;
   logic mem_write_o;
   logic iord_o;
   logic mem_ready_i;
   modport master (output mem_read_o, mem_write_o, iord_o, input mem_ready_i);
   modport slave (input mem_read_o, mem_write_o, iord_o, output mem_ready_i);
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control sequencer for a multi-cycle MIPS datapath with a shared, ready-handshaked memory port.
module multicycle_control_fsm #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [5:0]                       opcode_i,
   input  logic                             zero_i,
   multicycle_control_fsm_if.master         mem,
   output logic                             ir_write_o,
   output logic                             pc_write_o,
   output logic [1:0]                       pc_source_o,
   output logic                             alu_src_a_o,
   output logic [1:0]                       alu_src_b_o,
   output logic [2:0]                       alu_op_o,
   output logic                             reg_dst_o,
   output logic                             mem_to_reg_o,
   output logic                             reg_write_o,
   output logic                             illegal_o,
   output logic                             bus_error_o,
   output logic [3:0]                       state_o
);
   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_R_WB      = 4'd8,
      S_EXEC_I    = 4'd9,
      S_I_WB      = 4'd10,
      S_BRANCH    = 4'd11,
      S_JUMP      = 4'd12
   } state_t;
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;
   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait;
   logic       r_bus_error;
   logic       w_ready;
   logic       w_stall;
   logic       w_timeout;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_iord;
   assign w_ready = mem.mem_ready_i;
   assign w_stall = (r_state == S_FETCH || r_state == S_MEM_READ || r_state == S_MEM_WRITE) && !w_ready;
   assign w_timeout = w_stall && r_wait == 8'(WAIT_LIMIT - 1);
   assign mem.mem_read_o = w_mem_read;
   assign mem.mem_write_o = w_mem_write;
   assign mem.iord_o = w_iord;
   assign bus_error_o = r_bus_error;
   assign state_o = r_state;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_wait <= '0;
         r_bus_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || w_timeout) r_wait <= '0;
         else if (w_stall && r_wait != 8'hff) r_wait <= r_wait + 8'd1;
         if (w_timeout) r_bus_error <= 1'b1;
      end
   end
   always_comb begin
      w_next = S_FETCH;
      w_mem_read = 1'b0;
      w_mem_write = 1'b0;
      w_iord = 1'b0;
      ir_write_o = 1'b0;
      pc_write_o = 1'b0;
      pc_source_o = 2'b00;
      alu_src_a_o = 1'b0;
      alu_src_b_o = 2'b00;
      alu_op_o = 3'b000;
      reg_dst_o = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            w_mem_read = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write_o = w_ready;
            pc_write_o = w_ready;
            w_next = w_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            case (opcode_i)
               OP_R:                    w_next = S_EXEC_R;
               OP_ADDI, OP_ORI, OP_ANDI: w_next = S_EXEC_I;
               OP_LW, OP_SW:            w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:          w_next = S_BRANCH;
               OP_J:                    w_next = S_JUMP;
               default: begin
                  illegal_o = 1'b1;
                  w_next = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            w_next = opcode_i == OP_LW ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            w_mem_read = 1'b1;
            w_iord = 1'b1;
            w_next = w_ready ? S_MEM_WB : w_timeout ? S_FETCH : S_MEM_READ;
         end
         S_MEM_WB: begin
            reg_write_o = 1'b1;
            mem_to_reg_o = 1'b1;
            w_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            w_mem_write = 1'b1;
            w_iord = 1'b1;
            w_next = w_ready ? S_FETCH : w_timeout ? S_FETCH : S_MEM_WRITE;
         end
         S_EXEC_R: begin
            alu_src_a_o = 1'b1;
            alu_op_o = 3'b010;
            w_next = S_R_WB;
         end
         S_R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o = 1'b1;
            w_next = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o = opcode_i == OP_ORI ? 3'b011 : opcode_i == OP_ANDI ? 3'b100 : 3'b000;
            w_next = S_I_WB;
         end
         S_I_WB: begin
            reg_write_o = 1'b1;
            w_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o = 3'b001;
            pc_source_o = 2'b01;
            // beq takes the branch on zero, bne on not-zero
            pc_write_o = zero_i ^ (opcode_i == OP_BNE);
            w_next = S_FETCH;
         end
         S_JUMP: begin
            pc_source_o = 2'b10;
            pc_write_o = 1'b1;
            w_next = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: instruction-level reference model feeding a per-cycle scoreboard of expected control words.
module tb_multicycle_control_fsm;
   localparam int WL = 15;
   localparam logic [3:0] IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4, MEM_WB = 5,
                          MEM_WRITE = 6, EXEC_R = 7, R_WB = 8, EXEC_I = 9, I_WB = 10, BRANCH = 11, JUMP = 12;
   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                          OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LW = 6'h23, OP_SW = 6'h2b;
   typedef struct packed {
      logic [3:0] st;
      logic       mr, mw, iord, irw, pcw;
      logic [1:0] pcs;
      logic       sa;
      logic [1:0] sb;
      logic [2:0] op;
      logic       rd, m2r, rw, ill, be;
   } ctl_t;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       ir_write_o, pc_write_o, alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o, bus_error_o;
   logic [1:0] pc_source_o, alu_src_b_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;
   multicycle_control_fsm_if mem();
   multicycle_control_fsm #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .reset(reset), .opcode_i(opcode), .zero_i(zero), .mem(mem),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_source_o(pc_source_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
      .illegal_o(illegal_o), .bus_error_o(bus_error_o), .state_o(state_o)
   );
   always #5 clk = ~clk;
   ctl_t       q[$];
   ctl_t       act;
   int         checks = 0;
   int         failures = 0;
   logic       berr = 1'b0;
   logic [5:0] cur_op = '0;
   assign act = {state_o, mem.mem_read_o, mem.mem_write_o, mem.iord_o, ir_write_o, pc_write_o, pc_source_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o, bus_error_o};
   function automatic bit legal(input logic [5:0] op);
      return op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
   endfunction
   // Expected control word for one cycle spent in phase st with the given inputs.
   function automatic ctl_t model(input logic [3:0] st, input logic [5:0] op, input logic z, input logic rdy, input logic be);
      ctl_t e = '0;
      e.st = st;
      e.be = be;
      if (st == FETCH) begin e.mr = 1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      if (st == DECODE) begin e.sb = 2'b11; e.ill = !legal(op); end
      if (st == MEM_ADDR) begin e.sa = 1; e.sb = 2'b10; end
      if (st == MEM_READ) begin e.mr = 1; e.iord = 1; end
      if (st == MEM_WB) begin e.rw = 1; e.m2r = 1; end
      if (st == MEM_WRITE) begin e.mw = 1; e.iord = 1; end
      if (st == EXEC_R) begin e.sa = 1; e.op = 3'b010; end
      if (st == R_WB) begin e.rw = 1; e.rd = 1; end
      if (st == EXEC_I) begin e.sa = 1; e.sb = 2'b10; e.op = op == OP_ORI ? 3'b011 : op == OP_ANDI ? 3'b100 : 3'b000; end
      if (st == I_WB) e.rw = 1;
      if (st == BRANCH) begin e.sa = 1; e.op = 3'b001; e.pcs = 2'b01; e.pcw = z ^ (op == OP_BNE); end
      if (st == JUMP) begin e.pcs = 2'b10; e.pcw = 1; end
      return e;
   endfunction
   always @(negedge clk) begin
      if (q.size() > 0) begin
         ctl_t e;
         e = q.pop_front();
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL ctl_word t=%0t state=%0d got=%h want=%h", $time, state_o, act, e);
         end
      end
   end
   task automatic rst_cycle(input logic r);
      @(posedge clk); #1;
      reset = r;
      mem.mem_ready_i = 1'($urandom);
      if (!r) berr = 1'b0;
      q.push_back('0);
   endtask
   task automatic step(input logic [3:0] st, input logic rdy, input logic z);
      @(posedge clk); #1;
      opcode = cur_op;
      zero = z;
      mem.mem_ready_i = rdy;
      q.push_back(model(st, cur_op, z, rdy, berr));
   endtask
   // n not-ready cycles then ready; aborts with ok=0 once the wait limit is hit.
   task automatic mem_phase(input logic [3:0] st, input int n, output bit ok);
      int w = 0;
      ok = 0;
      repeat (300) begin
         if (n == 0) begin
            step(st, 1'b1, 1'($urandom));
            ok = 1;
            return;
         end
         step(st, 1'b0, 1'($urandom));
         if (w == WL - 1) begin
            berr = 1'b1;
            return;
         end
         w++;
         n--;
      end
   endtask
   task automatic run_instr(input logic [5:0] op, input logic z, input int fs, input int ms);
      bit ok;
      int n = fs;
      cur_op = op;
      mem_phase(FETCH, n, ok);
      if (!ok) mem_phase(FETCH, 0, ok);
      step(DECODE, 1'($urandom), 1'($urandom));
      case (op)
         OP_R: begin step(EXEC_R, 1'($urandom), 1'($urandom)); step(R_WB, 1'($urandom), 1'($urandom)); end
         OP_ADDI, OP_ORI, OP_ANDI: begin step(EXEC_I, 1'($urandom), 1'($urandom)); step(I_WB, 1'($urandom), 1'($urandom)); end
         OP_LW: begin
            step(MEM_ADDR, 1'($urandom), 1'($urandom));
            mem_phase(MEM_READ, ms, ok);
            if (ok) step(MEM_WB, 1'($urandom), 1'($urandom));
         end
         OP_SW: begin
            step(MEM_ADDR, 1'($urandom), 1'($urandom));
            mem_phase(MEM_WRITE, ms, ok);
         end
         OP_BEQ, OP_BNE: step(BRANCH, 1'($urandom), z);
         OP_J: step(JUMP, 1'($urandom), 1'($urandom));
         default: ;
      endcase
   endtask
   function automatic int pick_stall();
      int r = $urandom_range(0, 15);
      return r == 0 ? 20 : r < 8 ? 0 : $urandom_range(1, 4);
   endfunction
   initial begin
      logic [5:0] ops[9] = '{OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
      bit ok;
      mem.mem_ready_i = 1'b0;
      repeat (3) rst_cycle(1'b0);
      rst_cycle(1'b1);
      run_instr(OP_R, 1'b0, 0, 0);
      run_instr(OP_LW, 1'b0, 0, 3);
      run_instr(OP_BEQ, 1'b1, 0, 0);
      run_instr(OP_BNE, 1'b1, 0, 0);
      run_instr(OP_BNE, 1'b0, 0, 0);
      run_instr(6'h3f, 1'b0, 0, 0);
      run_instr(OP_J, 1'b0, 20, 0);
      run_instr(OP_SW, 1'b0, 2, 20);
      run_instr(OP_LW, 1'b0, 1, 14);
      repeat (150) begin
         int k = $urandom_range(0, 9);
         logic [5:0] op = k < 9 ? ops[k] : 6'($urandom);
         run_instr(op, 1'($urandom), pick_stall(), pick_stall());
      end
      run_instr(OP_SW, 1'b0, 0, 20);
      cur_op = OP_LW;
      mem_phase(FETCH, 0, ok);
      step(DECODE, 1'b1, 1'b0);
      rst_cycle(1'b0);
      rst_cycle(1'b0);
      rst_cycle(1'b1);
      run_instr(OP_ADDI, 1'b0, 0, 0);
      run_instr(OP_ORI, 1'b0, 1, 0);
      repeat (2) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain left=%0d want=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style control state machine that sequences a multi-cycle MIPS datapath built from the existing register file, ALU, ALU control, sign-extend and mux blocks, sharing one memory port between instruction and data.
- Decodes the latched opcode and walks each instruction through fetch/decode/execute/memory/write-back.
- Drives all datapath enables and mux selects.
- Handles a ready handshake on the shared memory, with a timeout.
- Supports: R-type, addi, ori, andi, lw, sw, beq, bne, j.

Parameters:
WAIT_LIMIT, 15, maximum consecutive not-ready cycles tolerated in a memory state before abort (1..255).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset; clears state and flags immediately.
opcode_i  input  6  instruction register bits [31:26]; stable outside FETCH.
zero_i  input  1  ALU zero flag.
mem_ready_i  input  1  memory has completed the current read/write this cycle.
mem_read_o  output  1  memory read request.
mem_write_o  output  1  memory write request.
iord_o  output  1  memory address select: 0 = PC, 1 = ALU-out register.
ir_write_o  output  1  instruction register load enable.
pc_write_o  output  1  final PC load enable (branch condition resolved internally).
pc_source_o  output  2  PC source: 00 = ALU result, 01 = ALU-out register (branch target), 10 = jump target.
alu_src_a_o  output  1  ALU A select: 0 = PC, 1 = rs data.
alu_src_b_o  output  2  ALU B select: 00 = rt data, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
alu_op_o  output  3  to ALU control: 000 add, 001 sub, 010 funct-decoded, 011 or, 100 and.
reg_dst_o  output  1  write register select: 0 = rt, 1 = rd.
mem_to_reg_o  output  1  write-back select: 0 = ALU-out, 1 = memory data register.
reg_write_o  output  1  register file write enable.
illegal_o  output  1  unsupported opcode seen in DECODE.
bus_error_o  output  1  sticky memory timeout flag.
state_o  output  4  current state encoding (debug).

Behaviour:
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12. Any other value goes to FETCH.
- Reset (reset = 0): state becomes IDLE, wait counter = 0, bus_error_o = 0. All outputs are 0 in IDLE.
- IDLE: goes to FETCH unconditionally on the first clock edge after reset release.
- Outputs are decoded from state only, except where noted below. Every control output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, src_a = 0, src_b = 01, alu_op = 000, pc_source = 00.
  - When mem_ready_i = 1: ir_write = 1 and pc_write = 1 in that same cycle, then go to DECODE. Otherwise hold in FETCH.
- DECODE:
  - Outputs: src_a = 0, src_b = 11, alu_op = 000 (branch target precompute).
  - Next state by opcode: 000000 → EXEC_R; 001000, 001101, 001100 → EXEC_I; 100011, 101011 → MEM_ADDR; 000100, 000101 → BRANCH; 000010 → JUMP.
  - Any other opcode: illegal_o = 1 for this cycle, then go to FETCH.
- MEM_ADDR: src_a = 1, src_b = 10, alu_op = 000. Go to MEM_READ if the opcode is lw, else MEM_WRITE.
- MEM_READ: mem_read = 1, iord = 1. Go to MEM_WB when mem_ready_i = 1.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Then FETCH.
- MEM_WRITE: mem_write = 1, iord = 1. Go to FETCH when mem_ready_i = 1.
- EXEC_R: src_a = 1, src_b = 00, alu_op = 010. Then R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Then FETCH.
- EXEC_I: src_a = 1, src_b = 10. alu_op = 000 for addi, 011 for ori, 100 for andi. Then I_WB.
- I_WB: reg_write = 1, reg_dst = 0. Then FETCH.
- BRANCH: src_a = 1, src_b = 00, alu_op = 001, pc_source = 01. pc_write = zero_i XOR (opcode == bne), decoded combinationally. Then FETCH.
- JUMP: pc_source = 10, pc_write = 1. Then FETCH.
- Cycle counts with ready always high: R-type/I-type 4, branch/jump 3, sw 4, lw 5.
- Wait counter (8 bits, saturating):
  - Cleared on every state transition.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready_i = 0.
  - If mem_ready_i = 0 and the counter equals WAIT_LIMIT − 1: bus_error_o is set (sticky until reset) and the state goes to FETCH, with no ir/pc/reg write.
  - A timeout in FETCH therefore retries the fetch.
- mem_ready_i is ignored outside memory states.
- Reset asserted mid-instruction: IDLE in the same cycle, all outputs 0, no partial write.

Test Plan:
1. Hold reset low 3 cycles, then release → state_o = 0 and all outputs 0 during reset; state_o = 1 and mem_read_o = 1 on the first edge after release.
2. opcode 000000, mem_ready_i = 1 → state_o sequence 1, 2, 7, 8, 1; alu_op_o = 010 in state 7; reg_write_o = 1 and reg_dst_o = 1 only in state 8.
3. lw (100011), mem_ready_i low for 3 cycles in MEM_READ → state 4 held 4 cycles with mem_read_o = 1 and iord_o = 1 throughout; then state 5 with mem_to_reg_o = 1 and reg_write_o = 1.
4. Branch cases:
   - beq with zero_i = 1 → pc_write_o = 1 and pc_source_o = 01 in state 11.
   - bne with zero_i = 1 → pc_write_o = 0.
   - bne with zero_i = 0 → pc_write_o = 1.
5. opcode 111111 → illegal_o = 1 for exactly one cycle in state 2; next state 1; reg_write_o never asserted.
6. WAIT_LIMIT = 15, mem_ready_i stuck low in FETCH → after 15 cycles in state 1: bus_error_o = 1 (stays 1), state re-enters 1 with counter = 0, no pc_write_o; reset clears bus_error_o.
